// File: rtl/fetch_stage.sv
// Instruction fetch for the 64-bit LEGv8 core: owns the PC, addresses IM and fills the IF/ID register.
// Latency: the PC presented in cycle N appears in IF/ID after the next rising edge.
// Backpressure: stall holds PC, IF/ID and count; a redirect overrides stall and flushes IF/ID.
module fetch_stage #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [63:0] IMEM_BYTES = 64'd64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] pc_addr,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  // HALT is not stored separately: it is a pure function of the PC, so any
  // PC update (reset, redirect, increment) moves the stage in or out of it.
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;

  logic [63:0] pc_q;
  logic [63:0] redirect_pc;
  logic [0:0]  state;

  // Word-align the redirect so pc_addr[1:0] can never be nonzero.
  assign redirect_pc = branch_target & ~64'h3;

  // Fetch stops as soon as the PC points past the end of the program image.
  assign state   = (pc_q >= IMEM_BYTES) ? HALT : RUN;
  assign halted  = (state == HALT);
  assign pc_addr = pc_q;

  // PC update: reset > redirect > stall > halt hold > sequential increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC & ~64'h3;
    end else if (branch_taken) begin
      pc_q <= redirect_pc;
    end else if (!stall && state == RUN) begin
      pc_q <= pc_q + 64'd4;
    end
  end

  // IF/ID register and fetch counter: load on a normal fetch, flush on a
  // redirect, insert bubbles while halted unless decode is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_pc    <= 64'h0;
      if_id_instr <= 32'h0;
      if_id_valid <= 1'b0;
      fetch_count <= 32'h0;
    end else if (branch_taken) begin
      if_id_pc    <= 64'h0;
      if_id_instr <= 32'h0;
      if_id_valid <= 1'b0;
    end else if (stall) begin
      if_id_valid <= if_id_valid;
    end else if (state == HALT) begin
      if_id_valid <= 1'b0;
    end else begin
      if_id_pc    <= pc_q;
      if_id_instr <= instruction;
      if_id_valid <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then
// randomized stall/redirect/reset traffic, all compared every cycle against
// a behavioural model of the fetch rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc_addr;
  logic [31:0] instruction;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] imem [16];

  // Behavioural model state
  logic [63:0] m_pc;
  logic [63:0] m_ipc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic [31:0] m_cnt;
  logic        model_ok = 1'b0;

  fetch_stage #(.RESET_PC(64'h0), .IMEM_BYTES(64'd64)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_addr      (pc_addr),
    .instruction  (instruction),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  // Combinational big-endian IM: one 32-bit word per 4-byte slot.
  assign instruction = (pc_addr < 64'd64) ? imem[pc_addr[5:2]] : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model: apply the fetch rules once per rising edge from the sampled inputs.
  always @(posedge clk) begin
    if (reset) begin
      m_pc = 64'h0; m_ipc = 64'h0; m_instr = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
      model_ok = 1'b1;
    end else if (branch_taken) begin
      m_pc = (branch_target / 4) * 4;
      m_ipc = 64'h0; m_instr = 32'h0; m_valid = 1'b0;
    end else if (stall) begin
      // everything holds
    end else if (m_pc >= 64) begin
      m_valid = 1'b0;
    end else begin
      m_ipc = m_pc; m_instr = imem[m_pc / 4]; m_valid = 1'b1;
      m_pc = m_pc + 4; m_cnt = m_cnt + 1;
    end
  end

  // Compare every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (model_ok) begin
      check("pc_addr",     pc_addr,             m_pc);
      check("if_id_pc",    if_id_pc,            m_ipc);
      check("if_id_instr", {32'h0, if_id_instr}, {32'h0, m_instr});
      check("if_id_valid", {63'h0, if_id_valid}, {63'h0, m_valid});
      check("halted",      {63'h0, halted},      {63'h0, (m_pc >= 64)});
      check("fetch_count", {32'h0, fetch_count}, {32'h0, m_cnt});
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
    for (int i = 0; i < 16; i++) imem[i] = $urandom;
    imem[0] = 32'hF840_0182;
    imem[1] = 32'hF840_01A3;
    imem[2] = 32'hAA01_0285;

    // Reset held two cycles
    step(2);
    check("rst_pc",    pc_addr, 64'h0);
    check("rst_valid", {63'h0, if_id_valid}, 64'h0);
    check("rst_count", {32'h0, fetch_count}, 64'h0);
    check("rst_halt",  {63'h0, halted}, 64'h0);

    // Sequential fetch of three words
    reset = 1'b0;
    step(3);
    check("seq_ipc",   if_id_pc, 64'h8);
    check("seq_instr", {32'h0, if_id_instr}, 64'hAA01_0285);
    check("seq_pc",    pc_addr, 64'd12);
    check("seq_count", {32'h0, fetch_count}, 64'd3);

    // Stall two edges at pc 12
    stall = 1'b1;
    step(2);
    check("stall_pc",    pc_addr, 64'd12);
    check("stall_ipc",   if_id_pc, 64'h8);
    check("stall_count", {32'h0, fetch_count}, 64'd3);
    stall = 1'b0;
    step(1);
    check("unstall_ipc", if_id_pc, 64'd12);

    // Redirect while stalled, unaligned target
    stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h2B;
    step(1);
    check("redir_pc",    pc_addr, 64'h28);
    check("redir_valid", {63'h0, if_id_valid}, 64'h0);
    check("redir_count", {32'h0, fetch_count}, 64'd4);
    stall = 1'b0; branch_taken = 1'b0;
    step(1);
    check("redir_ipc",   if_id_pc, 64'h28);
    check("redir_valid1", {63'h0, if_id_valid}, 64'h1);

    // Run to 60, then off the end of IM
    step(4);
    check("pre_halt_pc", pc_addr, 64'd60);
    step(1);
    check("halt_pc",   pc_addr, 64'd64);
    check("halt_flag", {63'h0, halted}, 64'h1);
    step(3);
    check("halt_hold_pc",    pc_addr, 64'd64);
    check("halt_hold_valid", {63'h0, if_id_valid}, 64'h0);
    check("halt_hold_count", {32'h0, fetch_count}, 64'd10);
    branch_taken = 1'b1; branch_target = 64'h10;
    step(1);
    check("unhalt_flag", {63'h0, halted}, 64'h0);
    branch_taken = 1'b0;
    step(1);
    check("unhalt_ipc",   if_id_pc, 64'h10);
    check("unhalt_valid", {63'h0, if_id_valid}, 64'h1);

    // Reset wins over redirect and stall
    reset = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h30;
    step(1);
    check("rst2_pc",    pc_addr, 64'h0);
    check("rst2_valid", {63'h0, if_id_valid}, 64'h0);
    check("rst2_count", {32'h0, fetch_count}, 64'h0);
    check("rst2_ipc",   if_id_pc, 64'h0);

    // Randomized traffic against the model
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(0, 99) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) branch_target = {$urandom, $urandom};
      else branch_target = 64'($urandom_range(0, 79));
      step(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
